// File: rtl/jk_reg_bank.sv
// jk_reg_bank: bank of WIDTH JK flip-flops with a shared clock, synchronous
// active-high reset and clock enable. The mode input selects how each bit's
// J/K pair is wired: external per-bit JK, up counter, down counter or shift
// register.
// Optional build macro: JK_REG_BANK_PARITY_EN adds a registered parity output
// that always equals ^q.
module jk_reg_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             sout
`ifdef JK_REG_BANK_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam logic [1:0] MODE_JK    = 2'b00;
  localparam logic [1:0] MODE_UP    = 2'b01;
  localparam logic [1:0] MODE_DOWN  = 2'b10;
  localparam logic [1:0] MODE_SHIFT = 2'b11;

  // Even-parity helper shared by the reset value and the update path.
  function automatic logic calc_parity(input logic [WIDTH-1:0] value);
    calc_parity = ^value;
  endfunction

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] qb_r;
  logic [WIDTH-1:0] carry_up_s;   // bit i: all lower bits are one
  logic [WIDTH-1:0] carry_dn_s;   // bit i: all lower bits are zero
  logic [WIDTH-1:0] j_s;
  logic [WIDTH-1:0] k_s;
  logic [WIDTH-1:0] q_next_s;

  // Counter toggle conditions: each bit toggles when every lower bit is one
  // (up) or zero (down); bit 0 always toggles. Built from masks so no bit
  // depends on another bit of the same vector.
  always_comb begin
    logic [WIDTH-1:0] low_mask_v;
    carry_up_s = {WIDTH{1'b0}};
    carry_dn_s = {WIDTH{1'b0}};
    low_mask_v = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      low_mask_v    = ({{(WIDTH-1){1'b0}}, 1'b1} << i) - {{(WIDTH-1){1'b0}}, 1'b1};
      carry_up_s[i] = &(q_r  | ~low_mask_v);
      carry_dn_s[i] = &(~q_r | ~low_mask_v);
    end
  end

  // Mode-selected J/K wiring; every mode funnels through the same JK update.
  always_comb begin
    j_s = {WIDTH{1'b0}};
    k_s = {WIDTH{1'b0}};
    case (mode)
      MODE_JK: begin
        j_s = j;
        k_s = k;
      end
      MODE_UP: begin
        j_s = carry_up_s;
        k_s = carry_up_s;
      end
      MODE_DOWN: begin
        j_s = carry_dn_s;
        k_s = carry_dn_s;
      end
      MODE_SHIFT: begin
        j_s = {q_r[WIDTH-2:0], sin};
        k_s = ~{q_r[WIDTH-2:0], sin};
      end
      default: begin
        j_s = {WIDTH{1'b0}};
        k_s = {WIDTH{1'b0}};
      end
    endcase
    // Characteristic equation: set on J with Q=0, keep Q=1 unless K.
    q_next_s = (j_s & ~q_r) | (~k_s & q_r);
  end

  // State register: reset beats enable, enable gates the JK update.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r  <= RESET_VAL;
      qb_r <= ~RESET_VAL;
    end else if (en) begin
      q_r  <= q_next_s;
      qb_r <= ~q_next_s;
    end else begin
      q_r  <= q_r;
      qb_r <= qb_r;
    end
  end

`ifdef JK_REG_BANK_PARITY_EN
  logic parity_r;

  // Parity register tracks the parity of the value q is about to take.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_r <= calc_parity(RESET_VAL);
    end else if (en) begin
      parity_r <= calc_parity(q_next_s);
    end else begin
      parity_r <= parity_r;
    end
  end

  assign parity = parity_r;
`endif

  // Terminal count decode: full scale when counting up, zero when counting down.
  always_comb begin
    tc = 1'b0;
    case (mode)
      MODE_UP:   tc = (q_r == {WIDTH{1'b1}});
      MODE_DOWN: tc = (q_r == {WIDTH{1'b0}});
      default:   tc = 1'b0;
    endcase
  end

  assign q    = q_r;
  assign qb   = qb_r;
  assign sout = q_r[WIDTH-1];

endmodule

// File: tb/tb_jk_reg_bank.sv
// Scoreboard bench for jk_reg_bank (WIDTH=4, RESET_VAL=0): a stimulus process
// computes the expected register state from the behavioural rules and queues
// it; a monitor pops and compares after every rising edge.
module tb_jk_reg_bank;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic         sin;
  logic [W-1:0] q;
  logic [W-1:0] qb;
  logic         tc;
  logic         sout;
`ifdef JK_REG_BANK_PARITY_EN
  logic         parity;
`endif

  jk_reg_bank #(.WIDTH(W), .RESET_VAL(4'b0000)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .j    (j),
    .k    (k),
    .sin  (sin),
    .q    (q),
    .qb   (qb),
    .tc   (tc),
    .sout (sout)
`ifdef JK_REG_BANK_PARITY_EN
    ,
    .parity (parity)
`endif
  );

  typedef struct {
    logic [W-1:0] q;
    logic         tc;
    logic         par;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   model_q = 0;   // behavioural state as a plain integer 0..15

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one edge worth of inputs and queue what the register must become.
  task automatic apply(input logic r, input logic e, input logic [1:0] m,
                       input logic [W-1:0] jv, input logic [W-1:0] kv,
                       input logic s);
    exp_t x;
    int   nq;
    @(negedge clk);
    rst = r; en = e; mode = m; j = jv; k = kv; sin = s;
    nq = model_q;
    if (r) begin
      nq = 0;
    end else if (e) begin
      case (m)
        2'b00: begin
          for (int b = 0; b < W; b++) begin
            case ({jv[b], kv[b]})
              2'b01:   nq = nq & ~(1 << b);
              2'b10:   nq = nq | (1 << b);
              2'b11:   nq = nq ^ (1 << b);
              default: nq = nq;
            endcase
          end
        end
        2'b01:   nq = (model_q + 1) % 16;
        2'b10:   nq = (model_q + 15) % 16;
        default: nq = ((model_q * 2) % 16) + (s ? 1 : 0);
      endcase
    end
    model_q = nq;
    x.q   = nq[W-1:0];
    x.tc  = (m == 2'b01 && nq == 15) || (m == 2'b10 && nq == 0);
    x.par = ((nq & 1) + ((nq >> 1) & 1) + ((nq >> 2) & 1) + ((nq >> 3) & 1)) % 2 == 1;
    exp_q.push_back(x);
  endtask

  task automatic preload(input logic [W-1:0] v);
    apply(1'b0, 1'b1, 2'b00, v, ~v, 1'b0);
  endtask

  // Monitor: after each rising edge compare DUT outputs to the oldest entry.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        n_vec++;
        if (q !== x.q) begin
          n_miss++;
          $display("FAIL q: got %b expected %b", q, x.q);
        end
        n_vec++;
        if (qb !== ~x.q) begin
          n_miss++;
          $display("FAIL qb: got %b expected %b", qb, ~x.q);
        end
        n_vec++;
        if (tc !== x.tc) begin
          n_miss++;
          $display("FAIL tc: got %b expected %b (mode %b q %b)", tc, x.tc, mode, x.q);
        end
        n_vec++;
        if (sout !== x.q[W-1]) begin
          n_miss++;
          $display("FAIL sout: got %b expected %b", sout, x.q[W-1]);
        end
`ifdef JK_REG_BANK_PARITY_EN
        n_vec++;
        if (parity !== x.par) begin
          n_miss++;
          $display("FAIL parity: got %b expected %b", parity, x.par);
        end
`endif
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    int wait_cycles;
    rst = 1'b0; en = 1'b0; mode = 2'b00; j = 4'b0000; k = 4'b0000; sin = 1'b0;

    // Reset from a non-zero state with en low; mode 10 decodes tc=1.
    apply(1'b1, 1'b0, 2'b00, 4'b0000, 4'b0000, 1'b0);
    preload(4'b1011);
    apply(1'b1, 1'b0, 2'b10, 4'b1111, 4'b1111, 1'b1);

    // Per-bit JK: set / reset / toggle / hold.
    apply(1'b0, 1'b1, 2'b00, 4'b1010, 4'b0110, 1'b0);
    apply(1'b0, 1'b1, 2'b00, 4'b1010, 4'b0110, 1'b0);

    // Up-count wrap.
    preload(4'b1110);
    apply(1'b0, 1'b1, 2'b01, 4'b0000, 4'b1111, 1'b0);
    apply(1'b0, 1'b1, 2'b01, 4'b1111, 4'b0000, 1'b0);

    // Down-count wrap.
    preload(4'b0001);
    apply(1'b0, 1'b1, 2'b10, 4'b0000, 4'b0000, 1'b1);
    apply(1'b0, 1'b1, 2'b10, 4'b0000, 4'b0000, 1'b1);

    // Shift in 1,0,1,1.
    preload(4'b0000);
    apply(1'b0, 1'b1, 2'b11, 4'b1111, 4'b1111, 1'b1);
    apply(1'b0, 1'b1, 2'b11, 4'b1111, 4'b1111, 1'b0);
    apply(1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000, 1'b1);
    apply(1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000, 1'b1);

    // Enable hold, reset mid-count, resume from reset value.
    preload(4'b0101);
    for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 2'b01, 4'b1111, 4'b0000, 1'b1);
    apply(1'b1, 1'b1, 2'b01, 4'b0000, 4'b0000, 1'b0);
    apply(1'b0, 1'b1, 2'b01, 4'b0000, 4'b0000, 1'b0);

    // Randomized traffic with occasional resets and enable drops.
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)));
    end

    // Drain the scoreboard with a bounded wait.
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
